march_element_sequencer: RTL and testbench

MARCH_ELEMENT_SEQUENCER -- requirements
Module: march_element_sequencer

---
 rtl/march_element_sequencer.sv | 128 ++++++++++++
 tb/tb_march_element_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/march_element_sequencer.sv
// rtl/march_element_sequencer.sv - march element sequencer: INIT/OPS/DONE control of the address counter and op slots.
// Optional MSEQ_PAUSE_EN adds pause_in, which freezes the OPS phase in place.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef IR_BFW_ADMD
`define IR_BFW_ADMD 2
`endif
`ifndef ADMD_LIUD
`define ADMD_LIUD 0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 1
`endif
`ifndef ADMD_AC
`define ADMD_AC 2
`endif
`ifndef ADMD_GC
`define ADMD_GC 3
`endif
`ifndef ADDR_UP
`define ADDR_UP 1
`endif

module march_element_sequencer #(
  parameter int tasw = `ADDR_WIDTH,
  parameter int admw = `IR_BFW_ADMD
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MSEQ_PAUSE_EN
  input  logic            pause_in,
`endif
  input  logic            start_in,
  input  logic            abort_in,
  input  logic [admw-1:0] admd_in,
  input  logic            updwn_in,
  input  logic [2:0]      nops_in,
  output logic            s_out,
  output logic            r_out,
  output logic            hold_out,
  output logic            updwn_out,
  output logic [admw-1:0] admd_out,
  output logic            op_valid_out,
  output logic [2:0]      op_idx_out,
  output logic            busy_out,
  output logic            done_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_OPS  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The pseudo-random mode walks one address fewer: an LFSR has no all-zero state.
  localparam logic [tasw:0] last_full = {1'b0, {tasw{1'b1}}};
  localparam logic [tasw:0] last_lfsr = last_full - 1'b1;

  logic [1:0]    state, state_nxt;
  logic [2:0]    nops;
  logic [tasw:0] addr_cnt;
  logic          pause;
  logic          op_go;
  logic          last_op;
  logic          final_addr;
  logic          in_init;

`ifdef MSEQ_PAUSE_EN
  assign pause = pause_in;
`else
  assign pause = 1'b0;
`endif

  always_comb begin
    final_addr = (admd_out == admw'(`ADMD_PRUD)) ? (addr_cnt == last_lfsr)
                                                 : (addr_cnt == last_full);
    last_op    = (op_idx_out == nops);
    op_go      = (state == ST_OPS) && !pause && !abort_in;
    in_init    = (state == ST_INIT) && !abort_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_in) state_nxt = ST_INIT;
      ST_INIT: state_nxt = ST_OPS;
      ST_OPS:  if (op_go && last_op && final_addr) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_in) state_nxt = ST_IDLE;
  end

  // Abort gates the slot outputs in the same cycle so nothing downstream acts on it.
  always_comb begin
    s_out        = in_init && (updwn_out == 1'(`ADDR_UP));
    r_out        = in_init && (updwn_out != 1'(`ADDR_UP));
    op_valid_out = op_go;
    hold_out     = !(in_init || (op_go && last_op && !final_addr));
    done_out     = (state == ST_DONE) && !abort_in;
    busy_out     = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_cnt   <= '0;
      op_idx_out <= 3'd0;
      updwn_out  <= 1'b0;
      admd_out   <= '0;
      nops       <= 3'd0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start_in && !abort_in) begin
        admd_out  <= admd_in;
        updwn_out <= updwn_in;
        nops      <= nops_in;
      end
      if ((state == ST_INIT) || abort_in) begin
        addr_cnt   <= '0;
        op_idx_out <= 3'd0;
      end else if (op_go) begin
        op_idx_out <= last_op ? 3'd0 : op_idx_out + 3'd1;
        if (last_op && !final_addr) addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_march_element_sequencer.sv
// tb/tb_march_element_sequencer.sv - randomized bench for march_element_sequencer against a per-cycle trace model.
`timescale 1ns/1ps
`ifndef ADMD_LIUD
`define ADMD_LIUD 0
`endif
`ifndef ADMD_PRUD
`define ADMD_PRUD 1
`endif
`ifndef ADMD_AC
`define ADMD_AC 2
`endif
`ifndef ADMD_GC
`define ADMD_GC 3
`endif
`ifndef ADDR_UP
`define ADDR_UP 1
`endif

module tb_march_element_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_in = 1'b0;
  logic       abort_in = 1'b0;
  logic [1:0] admd_in = 2'd0;
  logic       updwn_in = 1'b0;
  logic [2:0] nops_in = 3'd0;
`ifdef MSEQ_PAUSE_EN
  logic       pause_in = 1'b0;
`endif
  logic       s_out, r_out, hold_out, updwn_out, op_valid_out, busy_out, done_out;
  logic [1:0] admd_out;
  logic [2:0] op_idx_out;

  int         n_tests = 0;
  int         n_fail = 0;
  int         obs_slots, obs_hold0;
  logic       exp_updwn = 1'b0;
  logic [1:0] exp_admd = 2'd0;
  logic [11:0] exp_q[$];
  bit         pz_q[$];

  localparam logic UP = 1'(`ADDR_UP);
  localparam logic DN = !UP;

  always #5 clk = ~clk;

  march_element_sequencer #(.tasw(8), .admw(2)) dut (
    .clk(clk), .rst(rst),
`ifdef MSEQ_PAUSE_EN
    .pause_in(pause_in),
`endif
    .start_in(start_in), .abort_in(abort_in), .admd_in(admd_in), .updwn_in(updwn_in),
    .nops_in(nops_in), .s_out(s_out), .r_out(r_out), .hold_out(hold_out),
    .updwn_out(updwn_out), .admd_out(admd_out), .op_valid_out(op_valid_out),
    .op_idx_out(op_idx_out), .busy_out(busy_out), .done_out(done_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] pack(input logic s, input logic r, input logic hold, input logic opv,
                                       input logic [2:0] idx, input logic busy, input logic done,
                                       input logic up, input logic [1:0] admd);
    return {s, r, hold, opv, idx, busy, done, up, admd};
  endfunction

  function automatic logic [11:0] observed();
    return pack(s_out, r_out, hold_out, op_valid_out, op_valid_out ? op_idx_out : 3'd0,
                busy_out, done_out, updwn_out, admd_out);
  endfunction

  function automatic logic [11:0] idle_vec();
    return pack(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, exp_updwn, exp_admd);
  endfunction

  function automatic int addr_count(input logic [1:0] admd);
    return (admd == 2'(`ADMD_PRUD)) ? 255 : 256;
  endfunction

  // Expected cycle-by-cycle trace of one element, starting with the INIT cycle.
  task automatic build(input logic [1:0] admd, input logic up, input logic [2:0] nops,
                       input int pause_at, input int pause_len);
    int n_addr;
    int slot;
    n_addr = addr_count(admd);
    slot = 0;
    exp_q.delete();
    pz_q.delete();
    exp_q.push_back(pack(up == UP, up != UP, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, up, admd));
    pz_q.push_back(pause_len > 0);
    for (int a = 0; a < n_addr; a++) begin
      for (int k = 0; k <= int'(nops); k++) begin
        if (slot == pause_at) begin
          for (int p = 0; p < pause_len; p++) begin
            exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, up, admd));
            pz_q.push_back(1'b1);
          end
        end
        exp_q.push_back(pack(1'b0, 1'b0, !(k == int'(nops) && a != n_addr - 1), 1'b1, 3'(k),
                             1'b1, 1'b0, up, admd));
        pz_q.push_back(1'b0);
        slot++;
      end
    end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, up, admd));
    pz_q.push_back(pause_len > 0);
    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, up, admd));
    pz_q.push_back(1'b0);
  endtask

  task automatic run(input string tag, input logic [1:0] admd, input logic up, input logic [2:0] nops,
                     input int abort_at, input int rst_at, input int busy_start_at,
                     input int pause_at, input int pause_len);
    logic [11:0] want;
    obs_slots = 0;
    obs_hold0 = 0;
    build(admd, up, nops, pause_at, pause_len);
    @(negedge clk);
    start_in = 1'b1; admd_in = admd; updwn_in = up; nops_in = nops;
    #1 check_eq({tag, ":start"}, 32'(observed()), 32'(idle_vec()));
    exp_updwn = up;
    exp_admd = admd;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start_in = (i == busy_start_at);
      if (i == busy_start_at) begin
        admd_in = ~admd; updwn_in = ~up; nops_in = ~nops;
      end
      abort_in = (i == abort_at);
      rst = !(i == rst_at);
`ifdef MSEQ_PAUSE_EN
      pause_in = pz_q[i];
`endif
      #1;
      want = exp_q[i];
      if (i == abort_at) want = pack(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, up, admd);
      if (op_valid_out) obs_slots++;
      if (op_valid_out && !hold_out) obs_hold0++;
      check_eq($sformatf("%s[%0d]", tag, i), 32'(observed()), 32'(want));
      if (i == abort_at || i == rst_at) begin
        @(negedge clk);
        abort_in = 1'b0; rst = 1'b1; start_in = 1'b0;
        #1;
        if (i == rst_at) begin
          exp_updwn = 1'b0;
          exp_admd = 2'd0;
          check_eq({tag, ":rst_idx"}, 32'(op_idx_out), 32'd0);
        end
        check_eq({tag, ":after"}, 32'(observed()), 32'(idle_vec()));
        break;
      end
    end
    @(negedge clk);
    start_in = 1'b0; abort_in = 1'b0; rst = 1'b1;
`ifdef MSEQ_PAUSE_EN
    pause_in = 1'b0;
`endif
  endtask

  initial begin
    logic [1:0] ra;
    logic       ru;
    logic [2:0] rn;
    int         len, ab, pat;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_vec", 32'(observed()), 32'(idle_vec()));
    check_eq("reset_idx", 32'(op_idx_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("liud_up", 2'(`ADMD_LIUD), UP, 3'd0, -1, -1, -1, -1, 0);
    check_eq("liud_slots", obs_slots, 256);
    check_eq("liud_hold0", obs_hold0, 255);

    run("prud_dn", 2'(`ADMD_PRUD), DN, 3'd2, -1, -1, -1, -1, 0);
    check_eq("prud_slots", obs_slots, 765);
    check_eq("prud_hold0", obs_hold0, 254);

    run("abort", 2'(`ADMD_LIUD), UP, 3'd7, 10, -1, -1, -1, 0);
    run("busy_start", 2'(`ADMD_AC), DN, 3'd1, -1, -1, 100, -1, 0);
    check_eq("busy_slots", obs_slots, 512);
    run("rst_mid", 2'(`ADMD_GC), UP, 3'd3, -1, 1 + 100 * 4, -1, -1, 0);
    run("fresh", 2'(`ADMD_LIUD), UP, 3'd0, -1, -1, -1, -1, 0);
    check_eq("fresh_slots", obs_slots, 256);

`ifdef MSEQ_PAUSE_EN
    run("pause", 2'(`ADMD_LIUD), UP, 3'd1, -1, -1, -1, 301, 5);
    check_eq("pause_slots", obs_slots, 512);
    check_eq("pause_hold0", obs_hold0, 255);
`endif

    for (int t = 0; t < 6; t++) begin
      ra = 2'($urandom_range(0, 3));
      ru = 1'($urandom_range(0, 1));
      rn = 3'($urandom_range(0, 7));
      len = 1 + addr_count(ra) * (int'(rn) + 1) + 2;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 2)) : -1;
      pat = -1;
`ifdef MSEQ_PAUSE_EN
      pat = int'($urandom_range(0, addr_count(ra) * (int'(rn) + 1) - 1));
`endif
      run($sformatf("rnd%0d", t), ra, ru, rn, ab, -1, -1, pat, (pat >= 0) ? 3 : 0);
      if (ab < 0) check_eq($sformatf("rnd%0d_slots", t), obs_slots, addr_count(ra) * (int'(rn) + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
